// File: rtl/scr1_dmem_responder.sv
// rtl/scr1_dmem_responder.sv - SCR1 dmem responder: word-organised memory with programmable wait states
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

package scr1_dmem_pkg;
    typedef enum logic [1:0] {
        SCR1_MEM_CMD_RD    = 2'd0,
        SCR1_MEM_CMD_WR    = 2'd1,
        SCR1_MEM_CMD_ERROR = 2'd2
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'd0,
        SCR1_MEM_WIDTH_HWORD = 2'd1,
        SCR1_MEM_WIDTH_WORD  = 2'd2,
        SCR1_MEM_WIDTH_ERROR = 2'd3
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'd0,
        SCR1_MEM_RESP_RDY_OK = 2'd1,
        SCR1_MEM_RESP_RDY_ER = 2'd2
    } type_scr1_mem_resp_e;
endpackage

module scr1_dmem_responder
    import scr1_dmem_pkg::*;
#(
    parameter int unsigned                   SCR1_DMEM_DEPTH = 1024,
    parameter int unsigned                   SCR1_DMEM_WAIT  = 0,
    parameter logic [`SCR1_DMEM_AWIDTH-1:0]  SCR1_ADDR_BASE  = `SCR1_DMEM_AWIDTH'h00010000
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          dmem_req_ack,
    input  logic                          dmem_req,
    input  type_scr1_mem_cmd_e            dmem_cmd,
    input  type_scr1_mem_width_e          dmem_width,
    input  logic [`SCR1_DMEM_AWIDTH-1:0]  dmem_addr,
    input  logic [`SCR1_DMEM_DWIDTH-1:0]  dmem_wdata,
    output logic [`SCR1_DMEM_DWIDTH-1:0]  dmem_rdata,
    output type_scr1_mem_resp_e           dmem_resp
);
    localparam int unsigned AW    = `SCR1_DMEM_AWIDTH;
    localparam int unsigned DW    = `SCR1_DMEM_DWIDTH;
    localparam int unsigned IDX_W = $clog2(SCR1_DMEM_DEPTH);
    localparam logic [AW-1:0] SPAN = AW'(4 * SCR1_DMEM_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    type_scr1_mem_cmd_e cmd_q;
    logic [IDX_W-1:0]   idx_q;
    logic [3:0]         be_q;
    logic [DW-1:0]      wdata_q;
    logic               err_q;
    logic [DW-1:0]      rdata_q;
    logic [DW-1:0]      mem [SCR1_DMEM_DEPTH];

    logic               accept;
    logic [AW-1:0]      req_off;
    logic               req_err;
    logic [IDX_W-1:0]   req_idx;
    logic [3:0]         req_be;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [3:0]         wr_be;
    logic [DW-1:0]      wr_data;

    function automatic logic [3:0] be_of(input type_scr1_mem_width_e w, input logic [1:0] a);
        case (w)
            SCR1_MEM_WIDTH_BYTE:  be_of = 4'b0001 << a;
            SCR1_MEM_WIDTH_HWORD: be_of = 4'b0011 << a;
            default:              be_of = 4'b1111;
        endcase
    endfunction

    assign dmem_req_ack = (state_q != ST_WAIT);
    assign accept       = dmem_req & dmem_req_ack & ~rst;
    assign dmem_rdata   = rdata_q;
    assign dmem_resp    = (state_q != ST_RESP) ? SCR1_MEM_RESP_NOTRDY :
                          (err_q ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK);

    // Unsigned offset: addresses below the base wrap to huge values and fail the range check.
    always_comb begin
        req_off = dmem_addr - SCR1_ADDR_BASE;
        req_idx = req_off[IDX_W+1:2];
        req_be  = be_of(dmem_width, dmem_addr[1:0]);
        req_err = ((dmem_cmd != SCR1_MEM_CMD_RD) && (dmem_cmd != SCR1_MEM_CMD_WR))
                | (dmem_width == SCR1_MEM_WIDTH_ERROR)
                | ((dmem_width == SCR1_MEM_WIDTH_HWORD) && dmem_addr[0])
                | ((dmem_width == SCR1_MEM_WIDTH_WORD) && (dmem_addr[1:0] != 2'b00))
                | (req_off >= SPAN);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: begin
                if (accept) begin
                    if (SCR1_DMEM_WAIT == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(SCR1_DMEM_WAIT - 1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // The write commits on the edge that enters RESP, so a read accepted in RESP sees it.
    always_comb begin
        if (SCR1_DMEM_WAIT == 0) begin
            wr_en   = accept & (dmem_cmd == SCR1_MEM_CMD_WR) & ~req_err;
            wr_idx  = req_idx;
            wr_be   = req_be;
            wr_data = dmem_wdata;
        end else begin
            wr_en   = (state_q == ST_WAIT) & (cnt_q == 4'd0) & (cmd_q == SCR1_MEM_CMD_WR) & ~err_q & ~rst;
            wr_idx  = idx_q;
            wr_be   = be_q;
            wr_data = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            cmd_q   <= SCR1_MEM_CMD_RD;
            idx_q   <= '0;
            be_q    <= 4'd0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                cmd_q   <= dmem_cmd;
                idx_q   <= req_idx;
                be_q    <= req_be;
                wdata_q <= dmem_wdata;
                err_q   <= req_err;
                rdata_q <= (!req_err && dmem_cmd == SCR1_MEM_CMD_RD) ? mem[req_idx] : '0;
            end
        end
    end
endmodule

// File: tb/tb_scr1_dmem_responder.sv
// tb/tb_scr1_dmem_responder.sv - randomized and directed bench for scr1_dmem_responder against a transaction model
module tb_scr1_dmem_responder;
    import scr1_dmem_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [2:0]           req = 3'b000;
    type_scr1_mem_cmd_e   cmd = SCR1_MEM_CMD_RD;
    type_scr1_mem_width_e width = SCR1_MEM_WIDTH_WORD;
    logic [31:0]          addr = 32'h00010000;
    logic [31:0]          wdata = 32'h0;
    logic [2:0]           ack;
    logic [31:0]          rdata [3];
    type_scr1_mem_resp_e  resp [3];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    scr1_dmem_responder #(.SCR1_DMEM_DEPTH(1024), .SCR1_DMEM_WAIT(0), .SCR1_ADDR_BASE(32'h00010000)) u_w0 (
        .clk(clk), .rst(rst), .dmem_req_ack(ack[0]), .dmem_req(req[0]), .dmem_cmd(cmd),
        .dmem_width(width), .dmem_addr(addr), .dmem_wdata(wdata), .dmem_rdata(rdata[0]), .dmem_resp(resp[0]));
    scr1_dmem_responder #(.SCR1_DMEM_DEPTH(1024), .SCR1_DMEM_WAIT(3), .SCR1_ADDR_BASE(32'h00010000)) u_w3 (
        .clk(clk), .rst(rst), .dmem_req_ack(ack[1]), .dmem_req(req[1]), .dmem_cmd(cmd),
        .dmem_width(width), .dmem_addr(addr), .dmem_wdata(wdata), .dmem_rdata(rdata[1]), .dmem_resp(resp[1]));
    scr1_dmem_responder #(.SCR1_DMEM_DEPTH(1024), .SCR1_DMEM_WAIT(5), .SCR1_ADDR_BASE(32'h00010000)) u_w5 (
        .clk(clk), .rst(rst), .dmem_req_ack(ack[2]), .dmem_req(req[2]), .dmem_cmd(cmd),
        .dmem_width(width), .dmem_addr(addr), .dmem_wdata(wdata), .dmem_rdata(rdata[2]), .dmem_resp(resp[2]));

    function automatic int wt(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 5);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: cycles remaining until the response (-1 = nothing pending).
    int                  left [3] = '{-1, -1, -1};
    type_scr1_mem_resp_e exp_resp [3];
    logic [31:0]         exp_rdata [3];
    bit                  exp_rd [3];
    bit                  pw_v [3];
    int                  pw_idx [3];
    logic [3:0]          pw_be [3];
    logic [31:0]         pw_data [3];
    logic [31:0]         mem_m [3][1024];
    bit                  known [3][1024];

    function automatic bit is_err(input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w, input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'h00010000;
        if (c != SCR1_MEM_CMD_RD && c != SCR1_MEM_CMD_WR) return 1'b1;
        if (w == SCR1_MEM_WIDTH_ERROR) return 1'b1;
        if (w == SCR1_MEM_WIDTH_HWORD && a[0]) return 1'b1;
        if (w == SCR1_MEM_WIDTH_WORD && a[1:0] != 2'b00) return 1'b1;
        return off >= 32'd4096;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            bit          can_acc;
            bit          e;
            int          idx;
            logic [31:0] off;
            can_acc = (left[k] <= 0);
            if (rst) begin
                left[k] = -1;
                pw_v[k] = 1'b0;
            end else begin
                if (req[k] && can_acc) begin
                    e   = is_err(cmd, width, addr);
                    off = addr - 32'h00010000;
                    idx = int'(off[11:2]);
                    left[k]      = wt(k);
                    exp_resp[k]  = e ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
                    exp_rdata[k] = (e || cmd != SCR1_MEM_CMD_RD) ? 32'h0 : mem_m[k][idx];
                    exp_rd[k]    = !e && cmd == SCR1_MEM_CMD_RD && known[k][idx];
                    pw_v[k]      = !e && cmd == SCR1_MEM_CMD_WR;
                    pw_idx[k]    = idx;
                    pw_data[k]   = wdata;
                    pw_be[k]     = (width == SCR1_MEM_WIDTH_BYTE)  ? 4'(1 << addr[1:0]) :
                                   (width == SCR1_MEM_WIDTH_HWORD) ? 4'(3 << addr[1:0]) : 4'hF;
                end else if (left[k] > 0) begin
                    left[k]--;
                end else begin
                    left[k] = -1;
                end
                if (left[k] == 0 && pw_v[k]) begin
                    for (int b = 0; b < 4; b++)
                        if (pw_be[k][b]) mem_m[k][pw_idx[k]][8*b +: 8] = pw_data[k][8*b +: 8];
                    if (pw_be[k] == 4'hF) known[k][pw_idx[k]] = 1'b1;
                    pw_v[k] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            check($sformatf("ack%0d", k), 32'(ack[k]), 32'(left[k] <= 0));
            check($sformatf("resp%0d", k), 32'(resp[k]),
                  32'((left[k] == 0) ? exp_resp[k] : SCR1_MEM_RESP_NOTRDY));
            if (left[k] == 0 && (exp_resp[k] == SCR1_MEM_RESP_RDY_ER || exp_rd[k]))
                check($sformatf("rdata%0d", k), rdata[k], exp_rdata[k]);
        end
    end

    task automatic xact(input int k, input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                        input logic [31:0] a, input logic [31:0] d,
                        output type_scr1_mem_resp_e r, output logic [31:0] rd, output int lat, output int nack);
        bit acc;
        int guard;
        @(posedge clk); #1;
        cmd = c; width = w; addr = a; wdata = d; req[k] = 1'b1;
        acc = 1'b0; guard = 0;
        while (!acc && guard < 40) begin
            @(negedge clk); acc = ack[k];
            @(posedge clk); #1; guard++;
        end
        req[k] = 1'b0;
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        lat = 0; nack = 0; r = SCR1_MEM_RESP_NOTRDY; rd = 32'h0;
        while (r == SCR1_MEM_RESP_NOTRDY && lat < 40) begin
            @(negedge clk);
            lat++;
            r = resp[k]; rd = rdata[k];
            if (!ack[k]) nack++;
        end
    endtask

    type_scr1_mem_resp_e r;
    logic [31:0]         rd;
    int                  lat, nack;
    logic [31:0]         b2b [4] = '{32'h11111111, 32'hDEADA5EF, 32'h33333333, 32'h44444444};

    initial begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) check($sformatf("reset_rdata%0d", k), rdata[k], 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        xact(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10004, 32'hDEADBEEF, r, rd, lat, nack);
        check("wr_resp", 32'(r), 32'(SCR1_MEM_RESP_RDY_OK));
        check("wr_lat", lat, 1);
        xact(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10004, 32'h0, r, rd, lat, nack);
        check("rd_data", rd, 32'hDEADBEEF);
        check("rd_lat", lat, 1);
        xact(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h10005, 32'h0000A500, r, rd, lat, nack);
        xact(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10004, 32'h0, r, rd, lat, nack);
        check("byte_merge", rd, 32'hDEADA5EF);
        xact(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10000, 32'h11111111, r, rd, lat, nack);
        xact(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10008, 32'h33333333, r, rd, lat, nack);
        xact(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h1000C, 32'h44444444, r, rd, lat, nack);

        // Back-to-back reads then write/read to the same word with req held high.
        @(posedge clk); #1;
        cmd = SCR1_MEM_CMD_RD; width = SCR1_MEM_WIDTH_WORD; req[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = 32'h10000 + 32'(4 * i);
            @(posedge clk); #1;
            check($sformatf("b2b_resp%0d", i), 32'(resp[0]), 32'(SCR1_MEM_RESP_RDY_OK));
            check($sformatf("b2b_data%0d", i), rdata[0], b2b[i]);
        end
        cmd = SCR1_MEM_CMD_WR; addr = 32'h10000; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        cmd = SCR1_MEM_CMD_RD;
        @(posedge clk); #1;
        req[0] = 1'b0;
        check("raw_resp", 32'(resp[0]), 32'(SCR1_MEM_RESP_RDY_OK));
        check("raw_data", rdata[0], 32'hCAFEF00D);

        xact(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h10003, 32'hFFFFFFFF, r, rd, lat, nack);
        check("err_hword_resp", 32'(r), 32'(SCR1_MEM_RESP_RDY_ER));
        check("err_hword_rdata", rd, 32'h0);
        xact(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h11000, 32'hFFFFFFFF, r, rd, lat, nack);
        check("err_range_resp", 32'(r), 32'(SCR1_MEM_RESP_RDY_ER));
        xact(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10000, 32'h0, r, rd, lat, nack);
        check("err_unchanged0", rd, 32'hCAFEF00D);
        xact(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0FFFC, 32'h0, r, rd, lat, nack);
        check("err_below_resp", 32'(r), 32'(SCR1_MEM_RESP_RDY_ER));
        check("err_below_rdata", rd, 32'h0);
        xact(0, SCR1_MEM_CMD_ERROR, SCR1_MEM_WIDTH_WORD, 32'h10004, 32'h0, r, rd, lat, nack);
        check("err_cmd_resp", 32'(r), 32'(SCR1_MEM_RESP_RDY_ER));
        xact(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10004, 32'h0, r, rd, lat, nack);
        check("err_unchanged1", rd, 32'hDEADA5EF);

        xact(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10000, 32'h0, r, rd, lat, nack);
        check("w3_lat", lat, 4);
        check("w3_nack", nack, 3);
        check("w3_resp", 32'(r), 32'(SCR1_MEM_RESP_RDY_OK));

        // Reset with a request present must not accept it.
        @(posedge clk); #1;
        rst = 1'b1; req[0] = 1'b1; cmd = SCR1_MEM_CMD_RD;
        @(posedge clk); #1;
        rst = 1'b0; req[0] = 1'b0;
        @(negedge clk);
        check("rst_req_resp", 32'(resp[0]), 32'(SCR1_MEM_RESP_NOTRDY));

        // Reset two cycles into a WAIT=5 write discards it.
        xact(2, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10008, 32'hA5A5A5A5, r, rd, lat, nack);
        check("w5_lat", lat, 6);
        @(posedge clk); #1;
        cmd = SCR1_MEM_CMD_WR; width = SCR1_MEM_WIDTH_WORD; addr = 32'h10008; wdata = 32'h1; req[2] = 1'b1;
        @(posedge clk); #1 req[2] = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("w5_rst_ack", 32'(ack[2]), 32'd1);
        check("w5_rst_resp", 32'(resp[2]), 32'(SCR1_MEM_RESP_NOTRDY));
        xact(2, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10008, 32'h0, r, rd, lat, nack);
        check("w5_prior", rd, 32'hA5A5A5A5);

        for (int i = 0; i < 600; i++) begin
            int u;
            @(posedge clk); #1;
            req = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 99) == 0);
            u = $urandom_range(0, 9);
            cmd = (u < 5) ? SCR1_MEM_CMD_RD : ((u < 9) ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_ERROR);
            width = ($urandom_range(0, 7) == 0) ? SCR1_MEM_WIDTH_ERROR
                                                : type_scr1_mem_width_e'(2'($urandom_range(0, 2)));
            u = $urandom_range(0, 19);
            if (u == 18)      addr = 32'h0000FFFC;
            else if (u == 19) addr = 32'h00011000 + 32'(4 * $urandom_range(0, 3));
            else              addr = 32'h10000 + 32'(4 * (u % 8))
                                     + (($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : 32'h0);
            wdata = $urandom;
        end
        @(posedge clk); #1;
        req = 3'b000; rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
